charger_ctrl: RTL and testbench
===============================

# charger_ctrl

Digital charge-sequencing controller for the battery charger chip. It periodically requests ADC samples of battery voltage and temperature and runs the trickle, constant-current, constant-voltage and done/recharge state machine. It drives the 8-bit current-DAC code that sets `iforcedbat`. It sits in the core between the padded inputs (`en`, `sel[3:0]`) and the analog current-force stage.

## Interface

Parameters:
- `PERIOD`, 16'd1000: clock cycles between ADC requests.
- `ADC_TO`, 8'd64: maximum cycles from `adc_req` to `adc_valid`.
- `VCUTOFF`, 8'd100: trickle/CC threshold.
- `VTARGET`, 8'd200: CV regulation voltage.
- `VRECHARGE`, 8'd190: recharge threshold.
- `ITRICKLE`, 8'd20: trickle current code.
- `ITERM`, 8'd15: CV termination current code.
- `TMIN`, 8'd40: temperature window lower bound (inclusive).
- `TMAX`, 8'd180: temperature window upper bound (inclusive).
- `DEB`, 3'd4: consecutive samples required for CV termination.
- `MAX_SAMPLES`, 16'd3600: limit on samples spent in TC+CC+CV.

Ports (clock and reset first):
- `clk`  in  1  core clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `en`  in  1  charger enable, already synchronised.
- `sel`  in  4  CC current select.
- `adc_req`  out  1  one-cycle conversion request pulse.
- `adc_valid`  in  1  one-cycle pulse; `vbat`/`vtemp` are valid while it is high.
- `vbat`  in  8  battery voltage code.
- `vtemp`  in  8  battery temperature code.
- `icode`  out  8  current-DAC code.
- `state`  out  3  IDLE=0, TC=1, CC=2, CV=3, DONE=4, FAULT=5.
- `fault_code`  out  2  0 none, 1 temperature, 2 ADC timeout, 3 charge timeout.

## Operation

- Reset values: state IDLE, `icode`=0, `adc_req`=0, `fault_code`=0, all counters 0.
- In IDLE, `icode` is 0 and no ADC requests are issued. When `en`=1, go to TC and latch `iset = {sel, 4'hF}`. `sel` is ignored until the next IDLE exit.
- While not in IDLE or FAULT, the period counter counts to PERIOD-1, then pulses `adc_req` and opens a wait window.
  - The period counter keeps running during the wait.
  - If a request falls due while a wait is still open, that request is skipped.
- Wait window: if `adc_valid` has not arrived within ADC_TO cycles of `adc_req` (counting the request cycle as 1), go to FAULT with code 2.
- An `adc_valid` arriving outside a wait window is ignored.
- Each accepted sample is evaluated with this priority:
  1. `vtemp` < TMIN or `vtemp` > TMAX → FAULT, code 1.
  2. The sample counter reaches MAX_SAMPLES while in TC, CC or CV → FAULT, code 3.
  3. State rule:
     - TC: `icode`=ITRICKLE. If `vbat` ≥ VCUTOFF, go to CC.
     - CC: `icode`=`iset`. If `vbat` ≥ VTARGET, go to CV; `icode` is unchanged.
     - CV: if `vbat` > VTARGET, decrement `icode` (saturate at 0). If `vbat` < VTARGET, increment `icode` (saturate at `iset`). If equal, hold.
       - The termination counter increments when the updated `icode` ≤ ITERM and clears otherwise.
       - When the count reaches DEB, go to DONE.
     - DONE: `icode`=0. If `vbat` < VRECHARGE, clear the sample counter and go to CC; go to TC instead if `vbat` < VCUTOFF.
- The sample counter clears on entry to TC from IDLE and increments on every sample accepted in TC, CC or CV.
- FAULT: `icode`=0, `adc_req` is held 0, and `fault_code` is held. It is left only via `en`=0.
- `en`=0 in any state → IDLE on the next edge, with `icode`=0 and `fault_code`=0. This overrides every other event, including an `adc_valid` in the same cycle. Any open wait window is cancelled.

## Timing

- All outputs are registered.
- `state` and `icode` update on the edge after the `adc_valid` cycle (1-cycle latency).
- On entry to TC, `icode` becomes ITRICKLE on the same edge as the state change.
- The first `adc_req` is issued PERIOD cycles after leaving IDLE.
- `adc_req` is exactly 1 cycle wide.
- `rst` mid-charge: all outputs return to reset values on the next edge, regardless of `en`.
- `adc_valid` in the cycle the timeout expires: the sample is accepted and there is no fault.

## Test plan

- `en`=1, `sel`=4'hA, `vtemp`=100, `vbat` ramps 50→120→205 → TC with `icode`=20, then CC with `icode`=0xAF, then CV; `adc_req` spacing is 1000 cycles.
- In CV, hold `vbat`=210 → `icode` decrements by 1 per sample. After 4 samples with `icode` ≤ 15 → DONE with `icode`=0. Then `vbat`=185 → CC with `icode`=0xAF.
- Never answer `adc_req` → FAULT with `fault_code`=2 exactly 64 cycles after the request. Then `en`=0 → IDLE with `fault_code`=0.
- `vtemp`=181 during CC → FAULT with code 1 and `icode`=0 one cycle after `adc_valid`. With `vtemp`=180, no fault.
- Keep `vbat`=150 (CC) with MAX_SAMPLES=8 → FAULT with code 3 on the 8th sample.
- Drop `en` in the same cycle as `adc_valid` → IDLE and the sample is ignored. Assert `rst` mid-CV → all outputs 0 and `state`=IDLE next edge.

Source files
------------

// File: rtl/charger_ctrl.sv
// -----------------------------------------------------------------------------
// charger_ctrl
//
// Charge-sequencing controller for the battery charger. It requests an ADC
// sample of battery voltage and temperature every PERIOD cycles and runs the
// trickle (TC), constant-current (CC), constant-voltage (CV) and done/recharge
// sequence. Its output is the 8-bit current-DAC code that sets the forced
// battery current.
//
// Ports:
//   clk         in   1  core clock
//   rst         in   1  synchronous active-high reset
//   en          in   1  charger enable (already synchronised)
//   sel         in   4  CC current select, latched on leaving IDLE
//   adc_req     out  1  one-cycle conversion request pulse
//   adc_valid   in   1  one-cycle pulse, vbat/vtemp valid while high
//   vbat        in   8  battery voltage code
//   vtemp       in   8  battery temperature code
//   icode       out  8  current-DAC code
//   state       out  3  IDLE=0 TC=1 CC=2 CV=3 DONE=4 FAULT=5
//   fault_code  out  2  0 none, 1 temperature, 2 ADC timeout, 3 charge timeout
// -----------------------------------------------------------------------------
module charger_ctrl #(
    parameter logic [15:0] PERIOD      = 16'd1000,
    parameter logic [7:0]  ADC_TO      = 8'd64,
    parameter logic [7:0]  VCUTOFF     = 8'd100,
    parameter logic [7:0]  VTARGET     = 8'd200,
    parameter logic [7:0]  VRECHARGE   = 8'd190,
    parameter logic [7:0]  ITRICKLE    = 8'd20,
    parameter logic [7:0]  ITERM       = 8'd15,
    parameter logic [7:0]  TMIN        = 8'd40,
    parameter logic [7:0]  TMAX        = 8'd180,
    parameter logic [2:0]  DEB         = 3'd4,
    parameter logic [15:0] MAX_SAMPLES = 16'd3600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] sel,
    output logic       adc_req,
    input  logic       adc_valid,
    input  logic [7:0] vbat,
    input  logic [7:0] vtemp,
    output logic [7:0] icode,
    output logic [2:0] state,
    output logic [1:0] fault_code
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TC    = 3'd1,
        ST_CC    = 3'd2,
        ST_CV    = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_TEMP  = 2'd1;
    localparam logic [1:0] FC_ADCTO = 2'd2;
    localparam logic [1:0] FC_CHGTO = 2'd3;

    state_t      r_state;
    logic [7:0]  r_icode;
    logic [7:0]  r_iset;        // CC current latched from sel on leaving IDLE
    logic [1:0]  r_fault;
    logic        r_adc_req;
    logic        r_wait;        // a conversion has been requested, not yet answered
    logic [15:0] r_period_cnt;
    logic [7:0]  r_to_cnt;      // cycles spent in the wait window, request cycle = 1
    logic [15:0] r_samples;     // samples accepted in TC/CC/CV since charge start
    logic [2:0]  r_term;        // consecutive CV samples with icode at or below ITERM

    logic        w_charging;
    logic        w_period_hit;
    logic        w_accept;
    logic        w_timeout;
    logic        w_temp_bad;
    logic        w_max_hit;
    logic [15:0] w_samples_inc;
    logic [7:0]  w_cv_icode;
    logic [2:0]  w_term_next;

    assign w_charging    = (r_state == ST_TC) || (r_state == ST_CC) || (r_state == ST_CV);
    assign w_period_hit  = (r_period_cnt == PERIOD - 16'd1);
    // Samples only count while a request is outstanding; stray pulses are dropped.
    assign w_accept      = r_wait && adc_valid;
    // A sample landing in the last cycle of the window wins over the timeout.
    assign w_timeout     = r_wait && !adc_valid && (r_to_cnt == ADC_TO);
    assign w_temp_bad    = (vtemp < TMIN) || (vtemp > TMAX);
    assign w_samples_inc = r_samples + 16'd1;
    assign w_max_hit     = w_charging && (w_samples_inc >= MAX_SAMPLES);

    // CV regulation step: walk icode one code per sample toward VTARGET,
    // bounded below by 0 and above by the latched CC current.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_cv_icode unassigned (no latch).
        w_cv_icode = r_icode;
        if (vbat > VTARGET) begin
            if (r_icode != 8'd0) begin
                w_cv_icode = r_icode - 8'd1;
            end
        end else if (vbat < VTARGET) begin
            if (r_icode < r_iset) begin
                w_cv_icode = r_icode + 8'd1;
            end else begin
                w_cv_icode = r_iset;
            end
        end
    end

    assign w_term_next = (w_cv_icode <= ITERM) ? r_term + 3'd1 : 3'd0;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values; later assignments in this block override earlier ones.
        if (rst) begin
            r_state      <= ST_IDLE;
            r_icode      <= 8'd0;
            r_iset       <= 8'd0;
            r_fault      <= FC_NONE;
            r_adc_req    <= 1'b0;
            r_wait       <= 1'b0;
            r_period_cnt <= 16'd0;
            r_to_cnt     <= 8'd0;
            r_samples    <= 16'd0;
            r_term       <= 3'd0;
        end else if (!en) begin
            // Disable beats everything, including a sample arriving this cycle.
            r_state      <= ST_IDLE;
            r_icode      <= 8'd0;
            r_fault      <= FC_NONE;
            r_adc_req    <= 1'b0;
            r_wait       <= 1'b0;
            r_period_cnt <= 16'd0;
            r_to_cnt     <= 8'd0;
            r_samples    <= 16'd0;
            r_term       <= 3'd0;
        end else begin
            r_adc_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state      <= ST_TC;
                    r_icode      <= ITRICKLE;
                    r_iset       <= {sel, 4'hF};
                    r_period_cnt <= 16'd0;
                    r_samples    <= 16'd0;
                    r_term       <= 3'd0;
                    r_wait       <= 1'b0;
                    r_to_cnt     <= 8'd0;
                end

                ST_FAULT: begin
                    // Parked until en drops; no requests, no current.
                    r_icode <= 8'd0;
                end

                default: begin
                    // Free-running request timer, independent of the wait window.
                    if (w_period_hit) begin
                        r_period_cnt <= 16'd0;
                    end else begin
                        r_period_cnt <= r_period_cnt + 16'd1;
                    end

                    if (r_wait) begin
                        // A request falling due now is skipped.
                        if (adc_valid || (r_to_cnt == ADC_TO)) begin
                            r_wait <= 1'b0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 8'd1;
                        end
                    end else if (w_period_hit) begin
                        r_adc_req <= 1'b1;
                        r_wait    <= 1'b1;
                        r_to_cnt  <= 8'd1;
                    end

                    if (w_accept) begin
                        if (w_temp_bad) begin
                            r_state <= ST_FAULT;
                            r_fault <= FC_TEMP;
                            r_icode <= 8'd0;
                        end else if (w_max_hit) begin
                            r_state <= ST_FAULT;
                            r_fault <= FC_CHGTO;
                            r_icode <= 8'd0;
                        end else begin
                            case (r_state)
                                ST_TC: begin
                                    r_samples <= w_samples_inc;
                                    if (vbat >= VCUTOFF) begin
                                        r_state <= ST_CC;
                                        r_icode <= r_iset;
                                    end else begin
                                        r_icode <= ITRICKLE;
                                    end
                                end
                                ST_CC: begin
                                    r_samples <= w_samples_inc;
                                    r_icode   <= r_iset;
                                    if (vbat >= VTARGET) begin
                                        r_state <= ST_CV;
                                        r_term  <= 3'd0;
                                    end
                                end
                                ST_CV: begin
                                    r_samples <= w_samples_inc;
                                    r_icode   <= w_cv_icode;
                                    r_term    <= w_term_next;
                                    if (w_term_next == DEB) begin
                                        r_state <= ST_DONE;
                                        r_icode <= 8'd0;
                                        r_term  <= 3'd0;
                                    end
                                end
                                ST_DONE: begin
                                    r_icode <= 8'd0;
                                    // Recharge: a deeply discharged cell restarts in trickle.
                                    if (vbat < VCUTOFF) begin
                                        r_state   <= ST_TC;
                                        r_icode   <= ITRICKLE;
                                        r_samples <= 16'd0;
                                    end else if (vbat < VRECHARGE) begin
                                        r_state   <= ST_CC;
                                        r_icode   <= r_iset;
                                        r_samples <= 16'd0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_FAULT;
                        r_fault <= FC_ADCTO;
                        r_icode <= 8'd0;
                    end
                end
            endcase
        end
    end

    assign adc_req    = r_adc_req;
    assign icode      = r_icode;
    assign state      = r_state;
    assign fault_code = r_fault;

endmodule

// File: tb/tb_charger_ctrl.sv
// -----------------------------------------------------------------------------
// tb_charger_ctrl
//
// Scoreboard bench for charger_ctrl. The driver answers ADC requests with
// randomized or directed samples and, for each action, pushes the predicted
// (state, icode, fault_code) for a given cycle and the cycle of the next
// expected adc_req. The monitor, on every falling edge, pops and compares
// whatever is due that cycle and flags any adc_req not predicted.
// -----------------------------------------------------------------------------
module tb_charger_ctrl;

    localparam int C_PERIOD = 100;
    localparam int C_ADC_TO = 64;
    localparam int C_VCUT   = 100;
    localparam int C_VTGT   = 200;
    localparam int C_VRCH   = 190;
    localparam int C_ITRK   = 20;
    localparam int C_ITERM  = 15;
    localparam int C_TMIN   = 40;
    localparam int C_TMAX   = 180;
    localparam int C_DEB    = 4;
    localparam int C_MAX    = 40;

    localparam int S_IDLE  = 0;
    localparam int S_TC    = 1;
    localparam int S_CC    = 2;
    localparam int S_CV    = 3;
    localparam int S_DONE  = 4;
    localparam int S_FAULT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] sel = 4'd0;
    logic       adc_req;
    logic       adc_valid = 1'b0;
    logic [7:0] vbat = 8'd0;
    logic [7:0] vtemp = 8'd100;
    logic [7:0] icode;
    logic [2:0] state;
    logic [1:0] fault_code;

    charger_ctrl #(
        .PERIOD     (16'd100),
        .ADC_TO     (8'd64),
        .MAX_SAMPLES(16'd40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sel       (sel),
        .adc_req   (adc_req),
        .adc_valid (adc_valid),
        .vbat      (vbat),
        .vtemp     (vtemp),
        .icode     (icode),
        .state     (state),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int st;
        int ic;
        int fc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    req_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    mon_en = 1'b0;

    // Reference model of the charger as seen from the outside.
    int m_st = S_IDLE;
    int m_ic = 0;
    int m_fc = 0;
    int m_iset = 0;
    int m_samp = 0;
    int m_term = 0;
    int m_next_req = 0;

    task automatic check(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, expv);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (mon_en) begin
            if (req_q.size() > 0 && req_q[0] == cyc) begin
                check("adc_req_due", int'(adc_req), 1);
                req_q.delete(0);
            end else begin
                check("adc_req_quiet", int'(adc_req), 0);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_state"}, int'(state), e.st);
                check({nm, "_icode"}, int'(icode), e.ic);
                check({nm, "_fault"}, int'(fault_code), e.fc);
            end
        end
    end

    // ----------------------------------------------------------------- model
    function automatic bit m_active();
        return (m_st == S_TC) || (m_st == S_CC) || (m_st == S_CV) || (m_st == S_DONE);
    endfunction

    task automatic model_sample(input int vb, input int vt);
        if (vt < C_TMIN || vt > C_TMAX) begin
            m_st = S_FAULT; m_ic = 0; m_fc = 1;
            return;
        end
        if (m_st == S_TC || m_st == S_CC || m_st == S_CV) begin
            m_samp++;
            if (m_samp >= C_MAX) begin
                m_st = S_FAULT; m_ic = 0; m_fc = 3;
                return;
            end
        end
        case (m_st)
            S_TC: begin
                if (vb >= C_VCUT) begin m_st = S_CC; m_ic = m_iset; end
                else m_ic = C_ITRK;
            end
            S_CC: begin
                m_ic = m_iset;
                if (vb >= C_VTGT) begin m_st = S_CV; m_term = 0; end
            end
            S_CV: begin
                if (vb > C_VTGT) m_ic = (m_ic > 0) ? m_ic - 1 : 0;
                else if (vb < C_VTGT) m_ic = (m_ic < m_iset) ? m_ic + 1 : m_iset;
                m_term = (m_ic <= C_ITERM) ? m_term + 1 : 0;
                if (m_term >= C_DEB) begin m_st = S_DONE; m_ic = 0; end
            end
            S_DONE: begin
                m_ic = 0;
                if (vb < C_VCUT) begin m_st = S_TC; m_ic = C_ITRK; m_samp = 0; end
                else if (vb < C_VRCH) begin m_st = S_CC; m_ic = m_iset; m_samp = 0; end
            end
            default: ;
        endcase
    endtask

    // ---------------------------------------------------------------- driver
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_exp(input int c, input string nm);
        exp_t e;
        e.cyc = c; e.st = m_st; e.ic = m_ic; e.fc = m_fc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic enable(input int s);
        en  = 1'b1;
        sel = 4'(s);
        m_st = S_TC; m_ic = C_ITRK; m_fc = 0;
        m_iset = s * 16 + 15; m_samp = 0; m_term = 0;
        m_next_req = cyc + 1 + C_PERIOD;
        push_exp(cyc + 1, "enable");
        req_q.push_back(m_next_req);
        tick();
    endtask

    task automatic drop_en(input string nm);
        en = 1'b0;
        m_st = S_IDLE; m_ic = 0; m_fc = 0;
        push_exp(cyc + 1, nm);
        while (req_q.size() > 0 && req_q[req_q.size() - 1] > cyc) req_q.delete(req_q.size() - 1);
        tick();
    endtask

    // Answer the next request d cycles after it (d=0: in the request cycle).
    task automatic sample(input int vb, input int vt, input int d);
        int r = m_next_req;
        goto_cyc(r + d);
        adc_valid = 1'b1;
        vbat      = 8'(vb);
        vtemp     = 8'(vt);
        sel       = 4'($urandom_range(0, 15));
        model_sample(vb, vt);
        push_exp(cyc + 1, "sample");
        if (m_active()) begin
            m_next_req = r + C_PERIOD;
            req_q.push_back(m_next_req);
        end
        tick();
        adc_valid = 1'b0;
        vbat      = 8'($urandom_range(0, 255));
    endtask

    task automatic no_answer();
        int r = m_next_req;
        push_exp(r + C_ADC_TO - 1, "pre_timeout");
        m_st = S_FAULT; m_ic = 0; m_fc = 2;
        push_exp(r + C_ADC_TO, "adc_timeout");
        goto_cyc(r + C_ADC_TO + 1);
    endtask

    // A valid pulse outside any wait window carrying a sample that would fault.
    task automatic stray_valid();
        int c;
        if (m_next_req - cyc < 4) return;
        c = cyc + int'($urandom_range(0, m_next_req - cyc - 3));
        goto_cyc(c);
        adc_valid = 1'b1;
        vbat      = 8'($urandom_range(0, 255));
        vtemp     = 8'd255;
        push_exp(cyc + 1, "stray_valid");
        tick();
        adc_valid = 1'b0;
        vtemp     = 8'd100;
    endtask

    task automatic reset_mid(input string nm);
        rst = 1'b1;
        m_st = S_IDLE; m_ic = 0; m_fc = 0;
        push_exp(cyc + 1, nm);
        while (req_q.size() > 0 && req_q[req_q.size() - 1] > cyc) req_q.delete(req_q.size() - 1);
        tick();
        push_exp(cyc + 1, "rst_hold");
        tick();
        rst = 1'b0;
        en  = 1'b0;
        push_exp(cyc + 1, "rst_release");
        tick();
    endtask

    function automatic int rand_vbat();
        case (m_st)
            S_TC:    return int'($urandom_range(60, 140));
            S_CC:    return int'($urandom_range(150, 230));
            S_CV:    return int'($urandom_range(190, 230));
            default: return int'($urandom_range(80, 210));
        endcase
    endfunction

    function automatic int rand_vtemp();
        if ($urandom_range(0, 14) == 0)
            return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 39)) : int'($urandom_range(181, 255));
        return int'($urandom_range(40, 180));
    endfunction

    initial begin
        repeat (3) tick();
        mon_en = 1'b1;
        push_exp(cyc, "reset");
        rst = 1'b0;
        tick();

        // Ramp through TC, CC, CV with sel=A, then CV regulation both ways.
        enable(4'hA);
        sample(50, 100, 5);
        sample(120, 100, int'($urandom_range(0, 63)));
        sample(205, 100, int'($urandom_range(0, 63)));
        sample(210, 100, 0);
        sample(210, 100, 10);
        sample(199, 100, 20);
        sample(199, 100, 30);
        sample(199, 100, 40);
        sample(200, 100, 50);
        // en drops in the same cycle as a sample that would otherwise fault.
        goto_cyc(m_next_req + 7);
        adc_valid = 1'b1; vbat = 8'd150; vtemp = 8'd255;
        drop_en("en_drop_with_valid");
        adc_valid = 1'b0; vtemp = 8'd100;

        // Small iset: CV walks down to termination, DONE, recharge, temperature edges.
        enable(1);
        sample(150, 100, 3);
        sample(205, 100, 3);
        for (int k = 0; k < 30 && m_st == S_CV; k++) sample(210, 100, int'($urandom_range(0, 63)));
        sample(195, 100, 4);
        sample(185, 100, 4);
        sample(205, 100, 4);
        sample(190, 100, 4);
        sample(210, 180, 4);
        sample(210, 40, 4);
        sample(210, 181, 4);
        drop_en("en_drop_after_temp_fault");

        // ADC wait window: last-cycle answer accepted, silence faults.
        enable(int'($urandom_range(0, 15)));
        sample(150, 100, C_ADC_TO - 1);
        no_answer();
        drop_en("en_drop_after_adc_timeout");

        // Charge timeout: stuck in CC.
        enable(5);
        for (int k = 0; k < C_MAX + 5 && m_active(); k++) sample(150, 100, int'($urandom_range(0, 63)));
        drop_en("en_drop_after_charge_timeout");

        // Reset in the middle of CV with en still high.
        enable(3);
        sample(150, 100, 2);
        sample(205, 100, 2);
        goto_cyc(cyc + int'($urandom_range(1, 20)));
        reset_mid("rst_mid_cv");

        // DONE falls back to TC on a deep discharge, then low-temperature fault.
        enable(0);
        sample(150, 100, 1);
        sample(205, 100, 1);
        sample(210, 100, 1);
        sample(210, 100, 1);
        sample(200, 100, 1);
        sample(200, 100, 1);
        sample(90, 100, 1);
        sample(120, 100, 1);
        sample(120, 39, 1);
        drop_en("en_drop_after_low_temp");

        // Randomized sessions.
        for (int s = 0; s < 5; s++) begin
            enable(int'($urandom_range(0, 15)));
            for (int k = 0; k < 30 && m_active(); k++) begin
                if ($urandom_range(0, 29) == 0) begin
                    no_answer();
                end else begin
                    sample(rand_vbat(), rand_vtemp(), int'($urandom_range(0, C_ADC_TO - 1)));
                    if (m_active() && $urandom_range(0, 3) == 0) stray_valid();
                end
            end
            drop_en("session_end");
        end

        repeat (3) tick();
        check("exp_queue_drained", exp_q.size(), 0);
        check("req_queue_drained", req_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
